mod_txt_mem_p: RTL and testbench
================================

MOD_TXT_MEM_P -- requirements
Module: mod_txt_mem_p

Interface
REQ-001 Parameter CELL_BITS, default 128: cell width in bits; multiple of 32, 32..256.
REQ-002 Parameter DEPTH_LOG2, default 10: log2 of cell count.
REQ-003 Parameter BUS_BASE, default 16'h0080: required value of busAddr[31:16] for chip-select.
REQ-004 Parameter FONT_LAT, default 2: fontGlyph-to-fontData latency in cycles, 1..3.
REQ-005 Single clock; reset is synchronous and active-low.
REQ-006 clock  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-low.
REQ-008 pixCellIx  in  DEPTH_LOG2  display-side cell index.
REQ-009 cellData  out  CELL_BITS  display-side cell contents.
REQ-010 fontGlyph  in  16  glyph code; [9:7] bank select, [7:0] glyph.
REQ-011 fontData  out  64  8x8 glyph bitmap.
REQ-012 busAddr  in  32  bus address.
REQ-013 busData  inout  32  bus data; driven only when busOE and chip-select.
REQ-014 busOE  in  1  read strobe.
REQ-015 busWR  in  1  write strobe; valid only with busOE low.
REQ-016 busOK  out  1  read-done; high-Z unless busOE and chip-select.
REQ-017 busy  out  1  fill engine active.

Function
REQ-018 Chip-select SHALL be busAddr[31:16]==BUS_BASE; register space SHALL be busAddr[15:8]==8'hFF; all other selected addresses are cell space.
REQ-019 Cell space: W=log2(CELL_BITS/32); word select busAddr[W+1:2], cell index busAddr[W+1+DEPTH_LOG2:W+2].
REQ-020 Registers: CTRL0..CTRL3 at busAddr[4:2]=0..3, read/write general purpose; SCROLL at 4 (DEPTH_LOG2 bits, rest reads 0); FILLVAL at 5 (32 bits); FILLGO at 6 (write starts fill, write data ignored); STATUS at 7, read-only, {31'h0, busy}.
REQ-021 Display read: effective index = (pixCellIx + SCROLL) mod 2^DEPTH_LOG2; cellData SHALL present that cell exactly 2 cycles after pixCellIx is sampled; unaffected by bus traffic or fill.
REQ-022 Font: banks ASCII (256 glyphs), GFX1 and GFX2 (128 each); [9:7]=010 selects GFX2, 011 selects GFX1, all other codes ASCII; fontData valid FONT_LAT cycles after fontGlyph sampled.
REQ-023 Bus read FSM states IDLE, WAIT, DONE; IDLE->WAIT on busOE with chip-select; WAIT->DONE after 1 cycle (cell space) or immediately to DONE (register space); DONE holds while busOE and busAddr unchanged; any busAddr change in WAIT/DONE returns to WAIT; busOE low returns to IDLE.
REQ-024 busOK SHALL be 1 only in DONE, 0 in IDLE/WAIT while selected; busData in DONE = addressed word (cell space) or register value.
REQ-025 Cell-space read latency: busOK high on the 2nd rising edge after busOE/address stable; register-space: 1st edge.
REQ-026 Bus write: one 32-bit word written on each rising edge with busWR high, busOE low, chip-select; no acknowledge.
REQ-027 Fill: FILLGO write sets busy and counter 0; each cycle writes FILLVAL to every 32-bit word of cell[counter], increments counter; busy clears the cycle after cell 2^DEPTH_LOG2-1 is written.
REQ-028 Bus cell write during fill SHALL win the write port that cycle; fill counter SHALL stall one cycle, no fill write lost.
REQ-029 FILLGO written while busy SHALL restart fill from 0 with current FILLVAL.
REQ-030 FILLVAL/SCROLL writes during fill take effect next cycle.
REQ-031 Simultaneous busOE and busWR: treated as read; no write.

Reset
REQ-032 On reset low at a rising edge: cellData=0, fontData=0, busy=0, FSM=IDLE, CTRL0..3=0, SCROLL=0, FILLVAL=0, fill counter=0; fill aborted.
REQ-033 Cell and font memory contents SHALL NOT be reset; font banks and initial screen load from hex init files.

Structure
REQ-034 Shared package mod_txt_pkg: register offsets, FSM state encoding, font bank select codes.
REQ-035 Cell storage SHALL be CELL_BITS/32 block-RAM lanes of 2^DEPTH_LOG2 x 32, one write port, one display read port, one bus read port.
REQ-036 One sub-module natural: mod_txt_fill (counter, busy, stall handling).

Verification
REQ-037 Write 32'hDEADBEEF to 0x0080_0014 then read it back -> busOK low 1 cycle, high on 2nd edge, busData=32'hDEADBEEF.
REQ-038 SCROLL=3, cell 5 word0 = 32'h1234_5678, pixCellIx=2 -> cellData[31:0]=32'h1234_5678 two cycles later.
REQ-039 FILLVAL=32'h0720_0720, FILLGO -> busy high exactly 2^DEPTH_LOG2 cycles (1024 default); any cell reads all lanes 32'h0720_0720.
REQ-040 During fill, bus write 32'hA5A5A5A5 to cell 0 word0 once counter passes 0 -> busy extends 1 cycle; cell 0 word0 = 32'hA5A5A5A5.
REQ-041 fontGlyph=16'h0180 -> fontData = GFX1 entry 0 after FONT_LAT cycles; 16'h0041 -> ASCII 'A'.
REQ-042 Reset low mid-fill at counter 100 -> busy=0 next cycle, cellData=0, STATUS reads 0.

Source files
------------

// File: rtl/mod_txt_pkg.sv
// Shared definitions for the text-mode memory: register map, bus FSM states, glyph ROM.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mod_txt_pkg;

  // Register page selected by busAddr[15:8]
  localparam logic [7:0] REG_PAGE = 8'hFF;

  // Register offsets, busAddr[4:2]
  localparam logic [2:0] REG_CTRL0   = 3'd0;
  localparam logic [2:0] REG_CTRL1   = 3'd1;
  localparam logic [2:0] REG_CTRL2   = 3'd2;
  localparam logic [2:0] REG_CTRL3   = 3'd3;
  localparam logic [2:0] REG_SCROLL  = 3'd4;
  localparam logic [2:0] REG_FILLVAL = 3'd5;
  localparam logic [2:0] REG_FILLGO  = 3'd6;
  localparam logic [2:0] REG_STATUS  = 3'd7;

  // Bus read handshake states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } busSt_t;

  // Font bank select codes on fontGlyph[9:7]; anything else is ASCII
  localparam logic [2:0] BANK_GFX2 = 3'b010;
  localparam logic [2:0] BANK_GFX1 = 3'b011;

  // Glyph ROM layout: ASCII 0..255, GFX1 256..383, GFX2 384..511
  localparam logic [8:0] FONT_BASE_GFX1 = 9'h100;
  localparam logic [8:0] FONT_BASE_GFX2 = 9'h180;

  // Map a glyph code onto the flat glyph ROM index
  function automatic logic [8:0] fontIndex(input logic [9:0] code);
    logic [8:0] ix;
    ix = {1'b0, code[7:0]};
    case (code[9:7])
      BANK_GFX2: ix = FONT_BASE_GFX2 | {2'b00, code[6:0]};
      BANK_GFX1: ix = FONT_BASE_GFX1 | {2'b00, code[6:0]};
      default: ;
    endcase
    return ix;
  endfunction

  // Glyph ROM contents. Rows are top-to-bottom, MSB byte first. Glyphs without
  // artwork return their own ROM index so every bank entry is distinguishable.
  function automatic logic [63:0] fontRom(input logic [8:0] ix);
    logic [63:0] bits;
    bits = {55'h0, ix};
    case (ix)
      9'h041:         bits = 64'h183C_6666_7E66_6600; // 'A'
      FONT_BASE_GFX1: bits = 64'hFF81_8181_8181_81FF; // hollow box
      default: ;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/mod_txt_fill.sv
// Fill engine: walks every cell index once, asserting a whole-cell write each cycle.
// Latency: one cell per cycle; busy drops the cycle after the last cell is written.
// Backpressure: stall holds the counter for that cycle (the write port went elsewhere).
module mod_txt_fill
  import mod_txt_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  output logic                  busy,
  output logic [DEPTH_LOG2-1:0] fillIx,
  output logic                  fillWe
);

  localparam logic [DEPTH_LOG2-1:0] LAST_IX = '1;

  // A fill write happens on every busy cycle the write port is not taken
  assign fillWe = busy && !stall;

  // Counter and busy flag; a new start always restarts from cell 0
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy   <= 1'b0;
      fillIx <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      fillIx <= '0;
    end else if (fillWe) begin
      fillIx <= fillIx + DEPTH_LOG2'(1);
      if (fillIx == LAST_IX) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mod_txt_mem_p.sv
// Text-mode cell memory: scrolled display read port, glyph ROM, bus-mapped cells/registers, fill engine.
// Latency: cellData 2 cycles, fontData FONT_LAT cycles; bus read done on 2nd edge (cells) or 1st edge (registers).
// Backpressure: busOK stays low until read data is ready; bus cell writes stall the fill engine one cycle.
module mod_txt_mem_p
  import mod_txt_pkg::*;
#(
  parameter int          CELL_BITS  = 128,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [15:0] BUS_BASE   = 16'h0080,
  parameter int          FONT_LAT   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DEPTH_LOG2-1:0] pixCellIx,
  output logic [CELL_BITS-1:0]  cellData,
  input  logic [15:0]           fontGlyph,
  output logic [63:0]           fontData,
  input  logic [31:0]           busAddr,
  inout  logic [31:0]           busData,
  input  logic                  busOE,
  input  logic                  busWR,
  output logic                  busOK,
  output logic                  busy
);

  localparam int WORDS = CELL_BITS / 32;
  localparam int W     = (WORDS > 1) ? $clog2(WORDS) : 0;
  localparam int WS    = (W > 0) ? W : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Bus address decode
  logic                  chipSel;
  logic                  regSpace;
  logic [2:0]            regIx;
  logic [WS-1:0]         wordSel;
  logic [DEPTH_LOG2-1:0] cellIx;
  logic                  busCellWr;
  logic                  busRegWr;
  logic                  fillGo;

  assign chipSel   = (busAddr[31:16] == BUS_BASE);
  assign regSpace  = (busAddr[15:8] == REG_PAGE);
  assign regIx     = busAddr[4:2];
  assign wordSel   = (W == 0) ? '0 : busAddr[2 +: WS];
  assign cellIx    = busAddr[W+2 +: DEPTH_LOG2];
  // A strobe with busOE high is a read; writes need busOE low
  assign busCellWr = busWR && !busOE && chipSel && !regSpace;
  assign busRegWr  = busWR && !busOE && chipSel && regSpace;
  assign fillGo    = busRegWr && (regIx == REG_FILLGO);

  // Bit-bucket for address/glyph bits this configuration does not decode
  logic unusedBits;
  assign unusedBits = &{1'b0, busAddr[1:0], fontGlyph[15:10]};

  // Control registers
  logic [31:0]           ctrlReg [4];
  logic [DEPTH_LOG2-1:0] scrollReg;
  logic [31:0]           fillVal;

  // Register writes; FILLGO and STATUS hold no storage here
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) ctrlReg[k] <= '0;
      scrollReg <= '0;
      fillVal   <= '0;
    end else if (busRegWr) begin
      case (regIx)
        REG_CTRL0, REG_CTRL1, REG_CTRL2, REG_CTRL3: ctrlReg[regIx[1:0]] <= busData;
        REG_SCROLL:  scrollReg <= busData[DEPTH_LOG2-1:0];
        REG_FILLVAL: fillVal   <= busData;
        default: ;
      endcase
    end
  end

  // Register read mux
  logic [31:0] regValue;
  always_comb begin
    regValue = '0;
    case (regIx)
      REG_CTRL0, REG_CTRL1, REG_CTRL2, REG_CTRL3: regValue = ctrlReg[regIx[1:0]];
      REG_SCROLL:  regValue[DEPTH_LOG2-1:0] = scrollReg;
      REG_FILLVAL: regValue = fillVal;
      REG_STATUS:  regValue = {31'h0, busy};
      default: ;
    endcase
  end

  // Fill engine; a bus cell write takes the write port and stalls it
  logic [DEPTH_LOG2-1:0] fillIx;
  logic                  fillWe;

  mod_txt_fill #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) uFill (
    .clock (clock),
    .reset (reset),
    .start (fillGo),
    .stall (busCellWr),
    .busy  (busy),
    .fillIx(fillIx),
    .fillWe(fillWe)
  );

  // Shared write port: bus word write wins, otherwise fill writes all lanes
  logic [DEPTH_LOG2-1:0] wrIx;
  logic [31:0]           wrDat;
  assign wrIx  = busCellWr ? cellIx : fillIx;
  assign wrDat = busCellWr ? busData : fillVal;

  // Display index pipeline stage: apply scroll with natural wrap
  logic [DEPTH_LOG2-1:0] dispIx;
  always_ff @(posedge clock) begin
    if (!reset) dispIx <= '0;
    else        dispIx <= pixCellIx + scrollReg;
  end

  logic [CELL_BITS-1:0] busRow;
  logic [WS-1:0]        wordSelQ;

  // One 32-bit RAM lane per cell word
  for (genvar i = 0; i < WORDS; i++) begin : gLane
    logic [31:0] mem [DEPTH];
    logic [31:0] dispQ;
    logic [31:0] busQ;
    logic        laneWe;

    assign laneWe = busCellWr ? (wordSel == WS'(i)) : fillWe;

    // Write port and bus read port (contents are never reset)
    always_ff @(posedge clock) begin
      if (laneWe) mem[wrIx] <= wrDat;
      busQ <= mem[cellIx];
    end

    // Display read port with resettable output register
    always_ff @(posedge clock) begin
      if (!reset) dispQ <= '0;
      else        dispQ <= mem[dispIx];
    end

    assign cellData[32*i +: 32] = dispQ;
    assign busRow[32*i +: 32]   = busQ;
  end

  // Remember which word the bus read port fetched
  always_ff @(posedge clock) begin
    if (!reset) wordSelQ <= '0;
    else        wordSelQ <= wordSel;
  end

  // Select the fetched word; out-of-range word selects read as zero
  logic [31:0] busWord;
  always_comb begin
    busWord = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (wordSelQ == WS'(i)) busWord = busRow[32*i +: 32];
    end
  end

  // Glyph ROM lookup followed by a delay line to the requested latency
  logic [63:0] fontPipe [FONT_LAT];
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < FONT_LAT; k++) fontPipe[k] <= '0;
    end else begin
      fontPipe[0] <= fontRom(fontIndex(fontGlyph[9:0]));
      for (int k = 1; k < FONT_LAT; k++) fontPipe[k] <= fontPipe[k-1];
    end
  end
  assign fontData = fontPipe[FONT_LAT-1];

  // Bus read FSM: address changes restart the wait, busOE low or deselect returns to idle
  busSt_t      state;
  logic        okReg;
  logic [31:0] rdData;
  logic [31:0] lastAddr;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      okReg    <= 1'b0;
      rdData   <= '0;
      lastAddr <= '0;
    end else begin
      lastAddr <= busAddr;
      okReg    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (busOE && chipSel) begin
            if (regSpace) begin
              state  <= ST_DONE;
              okReg  <= 1'b1;
              rdData <= regValue;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        default: begin
          if (!(busOE && chipSel)) begin
            state <= ST_IDLE;
          end else if (busAddr != lastAddr) begin
            state <= ST_WAIT;
          end else begin
            state  <= ST_DONE;
            okReg  <= 1'b1;
            rdData <= regSpace ? regValue : busWord;
          end
        end
      endcase
    end
  end

  // Bus outputs float unless this block is read-selected
  assign busData = (busOE && chipSel) ? rdData : 32'hz;
  assign busOK   = (busOE && chipSel) ? okReg  : 1'bz;

endmodule

// File: tb/tb_mod_txt_mem_p.sv
// Directed bench for mod_txt_mem_p: bus reads/writes, scroll, glyph banks, fill, reset.
// Latency: checks exact cycle counts of each path.
// Backpressure: bounded waits on busy; expiry is reported as a failed check.
module tb_mod_txt_mem_p;

  localparam logic [31:0] A_CTRL1   = 32'h0080_FF04;
  localparam logic [31:0] A_SCROLL  = 32'h0080_FF10;
  localparam logic [31:0] A_FILLVAL = 32'h0080_FF14;
  localparam logic [31:0] A_FILLGO  = 32'h0080_FF18;
  localparam logic [31:0] A_STATUS  = 32'h0080_FF1C;

  logic         clock;
  logic         reset;
  logic [9:0]   pixCellIx;
  logic [127:0] cellData;
  logic [15:0]  fontGlyph;
  logic [63:0]  fontData;
  logic [31:0]  busAddr;
  wire  [31:0]  busData;
  logic         busOE;
  logic         busWR;
  wire          busOK;
  logic         busy;

  logic [31:0]  tbData;
  logic         tbDrive;
  int           checks;
  int           errors;
  int           busyCycles;
  int           c0;
  int           n;

  assign busData = tbDrive ? tbData : 32'hz;

  mod_txt_mem_p dut (
    .clock    (clock),
    .reset    (reset),
    .pixCellIx(pixCellIx),
    .cellData (cellData),
    .fontGlyph(fontGlyph),
    .fontData (fontData),
    .busAddr  (busAddr),
    .busData  (busData),
    .busOE    (busOE),
    .busWR    (busWR),
    .busOK    (busOK),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count rising edges at which busy was high before the edge
  initial busyCycles = 0;
  always @(posedge clock) if (busy === 1'b1) busyCycles <= busyCycles + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    busAddr = addr;
    tbData  = data;
    tbDrive = 1'b1;
    busOE   = 1'b0;
    busWR   = 1'b1;
    step();
    busWR   = 1'b0;
    tbDrive = 1'b0;
  endtask

  task automatic readCell(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    busAddr = addr;
    tbDrive = 1'b0;
    busOE   = 1'b1;
    step();
    chk({tag, "_okWait"}, 128'(busOK), 128'(1'b0));
    step();
    chk({tag, "_okDone"}, 128'(busOK), 128'(1'b1));
    chk({tag, "_data"}, 128'(busData), 128'(exp));
    busOE = 1'b0;
    step();
  endtask

  task automatic readReg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    busAddr = addr;
    tbDrive = 1'b0;
    busOE   = 1'b1;
    step();
    chk({tag, "_ok"}, 128'(busOK), 128'(1'b1));
    chk({tag, "_data"}, 128'(busData), 128'(exp));
    busOE = 1'b0;
    step();
  endtask

  task automatic waitIdle(input string tag);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, 128'(busy), 128'(1'b0));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    pixCellIx = '0;
    fontGlyph = '0;
    busAddr   = '0;
    busOE     = 1'b0;
    busWR     = 1'b0;
    tbData    = '0;
    tbDrive   = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_cellData", 128'(cellData), 128'h0);
    chk("rst_fontData", 128'(fontData), 128'h0);
    chk("rst_busy", 128'(busy), 128'(1'b0));
    reset = 1'b1;
    step();

    // Cell write/read: cell 1 word 1
    busWrite(32'h0080_0014, 32'hDEAD_BEEF);
    readCell("cellRd", 32'h0080_0014, 32'hDEAD_BEEF);

    // Register write/read, then an address change while still reading
    busWrite(A_CTRL1, 32'hCAFE_0001);
    busAddr = A_CTRL1;
    busOE   = 1'b1;
    step();
    chk("ctrl1_ok", 128'(busOK), 128'(1'b1));
    chk("ctrl1_data", 128'(busData), 128'h0000_0000_0000_0000_0000_0000_CAFE_0001);
    busAddr = 32'h0080_0014;
    step();
    chk("addrChg_okWait", 128'(busOK), 128'(1'b0));
    step();
    chk("addrChg_okDone", 128'(busOK), 128'(1'b1));
    chk("addrChg_data", 128'(busData), 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    busOE = 1'b0;
    step();

    // busOE with busWR is a read and must not write
    busWrite(32'h0080_0010, 32'h1111_1111);
    busAddr = 32'h0080_0010;
    busOE   = 1'b1;
    busWR   = 1'b1;
    step();
    step();
    chk("oeWr_ok", 128'(busOK), 128'(1'b1));
    busWR = 1'b0;
    busOE = 1'b0;
    step();
    readCell("oeWr_noWrite", 32'h0080_0010, 32'h1111_1111);

    // Scroll: only low 10 bits stored; cell 5 = pix 2 + 3
    busWrite(32'h0080_0030, 32'h3333_3333);
    busWrite(32'h0080_0050, 32'h1234_5678);
    busWrite(32'h0080_005C, 32'h9ABC_DEF0);
    busWrite(32'h0080_0020, 32'h2222_2222);
    busWrite(A_SCROLL, 32'hFFFF_FC03);
    pixCellIx = 10'd0;
    repeat (3) step();
    chk("scroll_cell3", 128'(cellData[31:0]), 128'h3333_3333);
    pixCellIx = 10'd2;
    step();
    chk("scroll_lat1", 128'(cellData[31:0]), 128'h3333_3333);
    step();
    chk("scroll_w0", 128'(cellData[31:0]), 128'h1234_5678);
    chk("scroll_w3", 128'(cellData[127:96]), 128'h9ABC_DEF0);
    pixCellIx = 10'h3FF;
    step();
    step();
    chk("scroll_wrap", 128'(cellData[31:0]), 128'h2222_2222);
    readReg("scrollRd", A_SCROLL, 32'h0000_0003);

    // Glyph banks and latency
    fontGlyph = 16'h0180;
    step();
    chk("font_lat1", 128'(fontData), 128'h0);
    step();
    chk("font_gfx1_0", 128'(fontData), 128'hFF81_8181_8181_81FF);
    fontGlyph = 16'h0041;
    step();
    step();
    chk("font_asciiA", 128'(fontData), 128'h183C_6666_7E66_6600);
    fontGlyph = 16'h0105;
    step();
    step();
    chk("font_gfx2_5", 128'(fontData), 128'h185);
    fontGlyph = 16'h0185;
    step();
    step();
    chk("font_gfx1_5", 128'(fontData), 128'h105);
    fontGlyph = 16'h0380;
    step();
    step();
    chk("font_ascii80", 128'(fontData), 128'h080);
    fontGlyph = 16'h0041;

    // Full fill: busy exactly 1024 cycles
    busWrite(A_FILLVAL, 32'h0720_0720);
    c0 = busyCycles;
    busWrite(A_FILLGO, 32'h0000_0000);
    chk("fill_busyRise", 128'(busy), 128'(1'b1));
    waitIdle("fill");
    chk("fill_cycles", 128'(busyCycles - c0), 128'd1024);
    readReg("fill_status", A_STATUS, 32'h0);
    readCell("fill_c1w1", 32'h0080_0014, 32'h0720_0720);
    readCell("fill_c1023w3", 32'h0080_3FFC, 32'h0720_0720);
    pixCellIx = 10'd77;
    step();
    step();
    chk("fill_disp", 128'(cellData), {4{32'h0720_0720}});

    // Bus write during fill stalls one cycle and survives
    busWrite(A_FILLVAL, 32'h0F0F_0F0F);
    c0 = busyCycles;
    busWrite(A_FILLGO, 32'h0);
    repeat (5) step();
    busWrite(32'h0080_0000, 32'hA5A5_A5A5);
    readReg("stall_status", A_STATUS, 32'h1);
    waitIdle("stall");
    chk("stall_cycles", 128'(busyCycles - c0), 128'd1025);
    readCell("stall_c0w0", 32'h0080_0000, 32'hA5A5_A5A5);
    readCell("stall_c0w1", 32'h0080_0004, 32'h0F0F_0F0F);
    readCell("stall_c5w0", 32'h0080_0050, 32'h0F0F_0F0F);

    // FILLVAL change mid-fill, then restart with the new value
    c0 = busyCycles;
    busWrite(A_FILLGO, 32'h0);
    repeat (8) step();
    busWrite(A_FILLVAL, 32'h5A5A_5A5A);
    busWrite(A_FILLGO, 32'h0);
    waitIdle("restart");
    chk("restart_cycles", 128'(busyCycles - c0), 128'd1034);
    readCell("restart_c0w0", 32'h0080_0000, 32'h5A5A_5A5A);

    // Reset mid-fill at counter 100
    busWrite(A_FILLGO, 32'h0);
    repeat (100) step();
    reset = 1'b0;
    step();
    chk("rstFill_busy", 128'(busy), 128'(1'b0));
    chk("rstFill_cellData", 128'(cellData), 128'h0);
    chk("rstFill_fontData", 128'(fontData), 128'h0);
    reset = 1'b1;
    repeat (3) step();
    chk("rstFill_aborted", 128'(busy), 128'(1'b0));
    readReg("rstFill_status", A_STATUS, 32'h0);
    readReg("rstFill_ctrl1", A_CTRL1, 32'h0);
    readReg("rstFill_fillval", A_FILLVAL, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
